rgmii_tx_framer: RTL
====================

// Module: rgmii_tx_framer
// PURPOSE
//  Parametrised successor to the bare RGMII DDR transmitter.
//  - Accepts a byte stream (valid/ready/last/user) in the tx_clk domain.
//  - Frames it: preamble, SFD, payload, pad to minimum length, optional FCS, inter-frame gap.
//  - Drives RGMII TXC/TX_CTL/TXD[3:0] through ODDR primitives. Sits between the MAC-side packet source and the PHY pins.
// PARAMETERS
//  PREAMBLE_BYTES   7   number of 0x55 bytes before the SFD (1..15)
//  MIN_FRAME_BYTES  60  minimum payload+pad length, FCS excluded (0 = no padding)
//  IFG_BYTES        12  idle byte-times after the last transmitted byte (>=1)
//  CNT_W            16  width of the statistics counters
// PORTS
//  tx_clk        in   1      125 MHz byte clock; also the source of rgmii_txc
//  tx_rst_n      in   1      asynchronous, active-low reset
//  s_tdata       in   8      payload byte
//  s_tvalid      in   1      s_tdata valid
//  s_tready      out  1      byte accepted on a tx_clk edge where s_tvalid&s_tready
//  s_tlast       in   1      last payload byte of the frame
//  s_tuser       in   1      abort flag, sampled only on the tlast beat
//  busy          out  1      high in every state except IDLE
//  tx_frames     out  CNT_W  count of frames completed without error; wraps
//  tx_errors     out  CNT_W  count of aborted/underrun frames; wraps
//  rgmii_txc     out  1      forwarded clock (ODDR D1=1, D2=0)
//  rgmii_tx_ctl  out  1      DDR: rising=TX_EN, falling=TX_EN^TX_ER
//  rgmii_txd     out  4      DDR: rising=byte[3:0], falling=byte[7:4]
// BEHAVIOUR
//  Reset: all outputs 0 except rgmii_txc; state=IDLE, counters=0.
//   - Data/ctl ODDRs use SRTYPE="ASYNC" with R=~tx_rst_n, so pins go low immediately, including mid-frame.
//   - The TXC ODDR is never reset; the clock keeps running.
//  Pipeline: FSM -> registered byte/en/er -> ODDR. A byte chosen on edge k appears on the pins from edge k+1.
//  FSM states and transitions:
//   - IDLE: s_tready=0. s_tvalid=1 -> PREAMBLE. The first byte is not consumed.
//   - PREAMBLE: PREAMBLE_BYTES cycles of 0x55, then SFD (one cycle 0xD5), then DATA.
//   - DATA: s_tready=1, send s_tdata, byte_cnt++ (saturating at MIN_FRAME_BYTES).
//     - tlast&!tuser: go to PAD if byte_cnt+1 < MIN_FRAME_BYTES, else to FCS (FCS enabled) or IFG (FCS disabled).
//     - tlast&tuser (abort): that byte is sent with TX_ER=1; go to IFG; tx_errors++; no pad and no FCS.
//     - !s_tvalid (underrun): send one byte 0x00 with TX_ER=1; go to DRAIN; tx_errors++.
//   - PAD: send 0x00 until byte_cnt = MIN_FRAME_BYTES, then FCS or IFG.
//   - FCS: 4 bytes, CRC LSB byte first, then IFG; tx_frames++ when the last byte is sent.
//     Without FCS, tx_frames++ on the last data/pad byte.
//   - DRAIN: s_tready=1, tx_en=0; discard beats until an accepted tlast, then IFG.
//   - IFG: tx_en=0 for IFG_BYTES cycles, then IDLE.
//     - Back-to-back frames: PREAMBLE starts on the edge after the gap, giving exactly IFG_BYTES idle bytes.
//  TX_EN=1 in PREAMBLE, SFD, DATA, PAD and FCS. TXD=0 whenever TX_EN=0 and TX_ER=0.
//  CRC-32: IEEE 802.3 poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
//   - Covers payload and pad bytes only; reseeded in SFD.
//  Counters are CNT_W bits, wrap from all-ones to 0, and at most one increment per cycle.
// CONFIGURATION
//  RGMII_TX_FCS_EN defined: FCS state built; the CRC is appended after payload/pad.
//  RGMII_TX_FCS_EN undefined:
//   - No CRC logic; the upstream source supplies the FCS inside the payload.
//   - Padding still applies; PAD/DATA go straight to IFG.
// STRUCTURE
//  Package rgmii_pkg:
//   - state enum; ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5.
//   - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE=32'hDEBB20E3.
//  Sub-module eth_crc32_d8: combinational next-CRC for an 8-bit input (crc_in, data -> crc_out).
//   - Instantiated only under RGMII_TX_FCS_EN.
//  ODDR instances live in this module (6 total: txc, tx_ctl, txd[3:0]).
// TESTING
//  1. 1-byte frame 0xAB, tlast=1, FCS on.
//     -> pins: 7x55, D5, AB, 59x00, 4 FCS bytes (receiver CRC residue = DEBB20E3).
//     -> then 12 idle byte-times; tx_frames=1.
//  2. 100-byte frame held back-to-back with a second 64-byte frame.
//     -> no pad on either frame; exactly 12 TX_EN=0 cycles between the last FCS byte and the next 0x55.
//  3. s_tvalid dropped at byte 20 of 80.
//     -> one byte with TX_CTL rising=1, falling=0 (error).
//     -> remaining beats accepted with TX_EN=0; tx_errors=1; IFG follows tlast.
//  4. tlast with s_tuser=1 at byte 30.
//     -> that byte carries TX_ER; no pad or FCS; tx_errors++; tx_frames unchanged.
//  5. tx_rst_n pulsed low during PAD.
//     -> tx_ctl/txd low asynchronously; txc still toggles; busy=0; counters=0.
//     -> next frame is framed cleanly.
//  6. FCS macro undefined, 64-byte frame.
//     -> 7x55, D5, 64 payload bytes, then IFG; no extra bytes.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII transmit framer: FSM states,
// Ethernet framing bytes and CRC-32 constants.
package rgmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DRAIN,
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Bit-reverses a word so the normal-form polynomial can drive an LSB-first CRC.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational next-state of the reflected IEEE 802.3 CRC-32 for one byte,
// data bits taken LSB first.
module eth_crc32_d8
  import rgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/rgmii_oddr.sv
// Behavioural same-edge DDR output register: D1 on the high phase, D2 on the
// low phase, both captured on the rising edge; async active-high reset.
module rgmii_oddr (
  input  logic clk,
  input  logic rst,
  input  logic d1,
  input  logic d2,
  output logic q
);

  logic q_rise;
  logic d2_hold;
  logic q_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rise  <= 1'b0;
      d2_hold <= 1'b0;
    end else begin
      q_rise  <= d1;
      d2_hold <= d2;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) q_fall <= 1'b0;
    else     q_fall <= d2_hold;
  end

  assign q = clk ? q_rise : q_fall;

endmodule

// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: preamble/SFD, payload, padding, optional FCS and IFG,
// driven onto the pins through DDR output registers. FCS built with RGMII_TX_FCS_EN.
module rgmii_tx_framer
  import rgmii_pkg::*;
#(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES       = 12,
  parameter int CNT_W           = 16
) (
  input  logic             tx_clk,
  input  logic             tx_rst_n,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic             s_tuser,
  output logic             busy,
  output logic [CNT_W-1:0] tx_frames,
  output logic [CNT_W-1:0] tx_errors,
  output logic             rgmii_txc,
  output logic             rgmii_tx_ctl,
  output logic [3:0]       rgmii_txd
);

  localparam int BCW = $clog2(MIN_FRAME_BYTES + 2);

  tx_state_t      state;
  logic [15:0]    cnt;
  logic [BCW-1:0] byte_cnt;
  logic [BCW-1:0] byte_cnt_inc;
  logic           pad_needed;
  logic [7:0]     tx_byte;
  logic           tx_en;
  logic           tx_er;

  assign s_tready     = (state == ST_DATA) || (state == ST_DRAIN);
  assign busy         = (state != ST_IDLE);
  assign byte_cnt_inc = (int'(byte_cnt) < MIN_FRAME_BYTES) ? byte_cnt + 1'b1 : byte_cnt;
  assign pad_needed   = (int'(byte_cnt) + 1 < MIN_FRAME_BYTES);

`ifdef RGMII_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] crc_next;

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    ((state == ST_PAD) ? 8'h00 : s_tdata),
    .crc_out (crc_next)
  );

  // CRC covers payload and pad only; reseeded while the SFD goes out.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n)                             crc <= CRC32_INIT;
    else if (state == ST_SFD)                  crc <= CRC32_INIT;
    else if ((state == ST_DATA && s_tvalid) ||
             (state == ST_PAD))                crc <= crc_next;
  end
`endif

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      byte_cnt  <= '0;
      tx_byte   <= '0;
      tx_en     <= 1'b0;
      tx_er     <= 1'b0;
      tx_frames <= '0;
      tx_errors <= '0;
    end else begin
      tx_byte <= '0;
      tx_en   <= 1'b0;
      tx_er   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (s_tvalid) state <= ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          tx_en   <= 1'b1;
          tx_byte <= ETH_PREAMBLE;
          cnt     <= cnt + 1'b1;
          if (int'(cnt) == PREAMBLE_BYTES - 1) state <= ST_SFD;
        end
        ST_SFD: begin
          tx_en    <= 1'b1;
          tx_byte  <= ETH_SFD;
          byte_cnt <= '0;
          state    <= ST_DATA;
        end
        ST_DATA: begin
          tx_en <= 1'b1;
          cnt   <= '0;
          if (!s_tvalid) begin
            tx_er     <= 1'b1;
            state     <= ST_DRAIN;
            tx_errors <= tx_errors + 1'b1;
          end else begin
            tx_byte  <= s_tdata;
            byte_cnt <= byte_cnt_inc;
            if (s_tlast) begin
              if (s_tuser) begin
                tx_er     <= 1'b1;
                state     <= ST_IFG;
                tx_errors <= tx_errors + 1'b1;
              end else if (pad_needed) begin
                state <= ST_PAD;
              end else begin
`ifdef RGMII_TX_FCS_EN
                state <= ST_FCS;
`else
                state     <= ST_IFG;
                tx_frames <= tx_frames + 1'b1;
`endif
              end
            end
          end
        end
        ST_PAD: begin
          tx_en    <= 1'b1;
          byte_cnt <= byte_cnt_inc;
          cnt      <= '0;
          if (!pad_needed) begin
`ifdef RGMII_TX_FCS_EN
            state <= ST_FCS;
`else
            state     <= ST_IFG;
            tx_frames <= tx_frames + 1'b1;
`endif
          end
        end
`ifdef RGMII_TX_FCS_EN
        // FCS is the complemented CRC, least significant byte first.
        ST_FCS: begin
          tx_en   <= 1'b1;
          tx_byte <= ~crc[{cnt[1:0], 3'b000} +: 8];
          cnt     <= cnt + 1'b1;
          if (cnt[1:0] == 2'd3) begin
            cnt       <= '0;
            state     <= ST_IFG;
            tx_frames <= tx_frames + 1'b1;
          end
        end
`endif
        ST_DRAIN: begin
          cnt <= '0;
          if (s_tvalid && s_tlast) state <= ST_IFG;
        end
        // A waiting frame skips IDLE so the gap is exactly IFG_BYTES long.
        ST_IFG: begin
          cnt <= cnt + 1'b1;
          if (int'(cnt) == IFG_BYTES - 1) begin
            cnt   <= '0;
            state <= s_tvalid ? ST_PREAMBLE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic oddr_rst;
  logic ctl_fall;

  assign oddr_rst = ~tx_rst_n;
  assign ctl_fall = tx_en ^ tx_er;

  rgmii_oddr u_oddr_txc (
    .clk (tx_clk), .rst (1'b0), .d1 (1'b1), .d2 (1'b0), .q (rgmii_txc)
  );

  rgmii_oddr u_oddr_ctl (
    .clk (tx_clk), .rst (oddr_rst), .d1 (tx_en), .d2 (ctl_fall), .q (rgmii_tx_ctl)
  );

  for (genvar i = 0; i < 4; i++) begin : g_txd
    rgmii_oddr u_oddr_txd (
      .clk (tx_clk), .rst (oddr_rst), .d1 (tx_byte[i]), .d2 (tx_byte[i+4]), .q (rgmii_txd[i])
    );
  end

endmodule
